// File: rtl/regfile_pkg.sv
// Shared types, default sizes and packed-port slicing helper for the scoreboarded register file.
package regfile_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } rf_state_e;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  // LSB of port `port` inside a packed vector of `width`-bit fields.
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_sb_bits.sv
// Per-register busy scoreboard: reserve at issue, clear at writeback, and WAW conflict pulse.
module regfile_sb_bits #(
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic [NREGS-1:0] busy,
  output logic             rsv_conflict
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy         <= '0;
      rsv_conflict <= 1'b0;
    end else begin
      rsv_conflict <= 1'b0;
      if (en) begin
        if (we && wa != '0) busy[wa] <= 1'b0;
        // NOTE: the later non-blocking assignment to the same bit wins, so a
        // same-cycle reserve overrides the writeback clear (new producer).
        if (rsv_en && rsv_addr != '0) begin
          busy[rsv_addr] <= 1'b1;
          rsv_conflict   <= busy[rsv_addr] && !(we && wa == rsv_addr);
        end
      end
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with NRD combinational read ports, one write port, busy scoreboard and post-reset clearing.
// Define REGFILE_BYPASS_EN for write-first reads; default is read-before-write.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic                init_done,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rbusy,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic                rsv_conflict
);

  rf_state_e         state;
  logic [AW-1:0]     clr_ptr;
  logic [XLEN-1:0]   rf [NREGS];
  logic [NREGS-1:0]  busy;

  // Clearing sequencer: walks registers 1..NREGS-1, then runs until the next reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_INIT;
      clr_ptr   <= AW'(1);
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          clr_ptr <= clr_ptr + AW'(1);
          if (clr_ptr == AW'(NREGS - 1)) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        ST_RUN:  init_done <= 1'b1;
        default: state <= ST_INIT;
      endcase
    end
  end

  // NOTE: storage has no reset term; contents are zeroed by the sequencer
  // instead, which keeps the array mappable to plain RAM/flop banks.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (state == ST_INIT)     rf[clr_ptr] <= '0;
      else if (we && wa != '0)  rf[wa]      <= wd;
    end
  end

  regfile_sb_bits #(.NREGS(NREGS)) u_sb (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (init_done),
    .we           (we),
    .wa           (wa),
    .rsv_en       (rsv_en),
    .rsv_addr     (rsv_addr),
    .busy         (busy),
    .rsv_conflict (rsv_conflict)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            b;

    assign a = ra[port_lsb(i, AW) +: AW];

    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
      d = '0;
      b = 1'b0;
      if (init_done && a != '0) begin
        d = rf[a];
        b = busy[a];
`ifdef REGFILE_BYPASS_EN
        if (we && wa == a) begin
          d = wd;
          b = 1'b0;
        end
`endif
      end
    end

    assign rd[port_lsb(i, XLEN) +: XLEN] = d;
    assign rbusy[i]                      = b;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: vector table plus init, bypass and mid-run reset sequences.
module tb_regfile_scoreboard;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                init_done;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rbusy;
  logic                we;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic                rsv_conflict;

  int total = 0;
  int bad   = 0;
  int cycles;

  always #5 clk = ~clk;

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .init_done    (init_done),
    .ra           (ra),
    .rd           (rd),
    .rbusy        (rbusy),
    .we           (we),
    .wa           (wa),
    .wd           (wd),
    .rsv_en       (rsv_en),
    .rsv_addr     (rsv_addr),
    .rsv_conflict (rsv_conflict)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        rb0;
    logic        rb1;
    logic        conf;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we       = 1'b0;
    wa       = '0;
    wd       = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
  endtask

  // Counts edges until init_done, pulsing ignored writes/reserves and checking reads stay zero.
  task automatic wait_init(input string tag);
    cycles = 0;
    while (init_done !== 1'b1 && cycles < 100) begin
      we       = 1'b1;
      wa       = 5'(cycles + 1);
      wd       = 32'hFFFF_FFFF;
      rsv_en   = 1'b1;
      rsv_addr = 5'(cycles + 1);
      ra       = {5'd31, 5'd4};
      @(negedge clk);
      check({tag, "_rd_during_init"},    rd[31:0] | rd[63:32], 32'h0);
      check({tag, "_rbusy_during_init"}, 32'(rbusy), 32'h0);
      tick();
      cycles++;
    end
    check({tag, "_init_latency"}, 32'(cycles), 32'd31);
    idle();
    ra = '0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd7,  5'd7,  32'h0,        32'h0,        1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 5'd7,  32'h00000055, 1'b0, 5'd0, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd7,  5'd7,  32'h55,       32'h55,       1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 5'd7,  5'd0,  32'h55,       32'h0,        1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 5'd7,  5'd0,  32'h55,       32'h0,        1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd7,  5'd7,  32'h55,       32'h55,       1'b1, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd7,  5'd9,  32'h55,       32'h0,        1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 5'd9,  32'h000000A5, 1'b1, 5'd9, 5'd7,  5'd0,  32'h55,       32'h0,        1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd9,  5'd9,  32'hA5,       32'hA5,       1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 5'd9,  32'h000000B6, 1'b1, 5'd9, 5'd7,  5'd0,  32'h55,       32'h0,        1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd9,  5'd9,  32'hB6,       32'hB6,       1'b1, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 5'd7,  32'h00000011, 1'b1, 5'd0, 5'd9,  5'd5,  32'hB6,       32'hDEADBEEF, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd7,  5'd0,  32'h11,       32'h0,        1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 5'd12, 32'h0000CAFE, 1'b0, 5'd0, 5'd7,  5'd9,  32'h11,       32'hB6,       1'b0, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd12, 5'd12, 32'hCAFE,     32'hCAFE,     1'b0, 1'b0, 1'b0};

    reset_n = 1'b0;
    ra      = '0;
    idle();
    repeat (2) tick();
    check("reset_init_done", 32'(init_done), 32'h0);
    check("reset_conflict",  32'(rsv_conflict), 32'h0);

    reset_n = 1'b1;
    wait_init("first");
    for (int r = 1; r < NREGS; r++) begin
      ra = {5'(r), 5'(r)};
      #1;
      check("post_init_rd0",   rd[31:0],  32'h0);
      check("post_init_rd1",   rd[63:32], 32'h0);
      check("post_init_rbusy", 32'(rbusy), 32'h0);
    end
    check("post_init_conflict", 32'(rsv_conflict), 32'h0);

    for (int i = 0; i < 18; i++) begin
      tick();
      we       = vecs[i].we;
      wa       = vecs[i].wa;
      wd       = vecs[i].wd;
      rsv_en   = vecs[i].rsv_en;
      rsv_addr = vecs[i].rsv_addr;
      ra       = {vecs[i].ra1, vecs[i].ra0};
      @(negedge clk);
      check($sformatf("vec%0d_rd0", i),    rd[31:0],            vecs[i].rd0);
      check($sformatf("vec%0d_rd1", i),    rd[63:32],           vecs[i].rd1);
      check($sformatf("vec%0d_rbusy0", i), 32'(rbusy[0]),       32'(vecs[i].rb0));
      check($sformatf("vec%0d_rbusy1", i), 32'(rbusy[1]),       32'(vecs[i].rb1));
      check($sformatf("vec%0d_conf", i),   32'(rsv_conflict),   32'(vecs[i].conf));
    end

    // Write port racing a read of the same busy register.
    tick();
    idle();
    we = 1'b1; wa = 5'd3; wd = 32'h33;
    tick();
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd3;
    tick();
    idle();
    we = 1'b1; wa = 5'd3; wd = 32'h77;
    ra = {5'd3, 5'd0};
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    check("bypass_rd1_same_cycle",    rd[63:32],     32'h77);
    check("bypass_rbusy1_same_cycle", 32'(rbusy[1]), 32'h0);
`else
    check("nobypass_rd1_same_cycle",    rd[63:32],     32'h33);
    check("nobypass_rbusy1_same_cycle", 32'(rbusy[1]), 32'h1);
`endif
    tick();
    idle();
    @(negedge clk);
    check("write_rd1_next_cycle",    rd[63:32],     32'h77);
    check("write_rbusy1_next_cycle", 32'(rbusy[1]), 32'h0);

    // Reset in the middle of operation with x4 busy and loaded.
    tick();
    we = 1'b1; wa = 5'd4; wd = 32'h99;
    tick();
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd4;
    tick();
    idle();
    ra = {5'd4, 5'd4};
    #1;
    check("pre_reset_rd0",    rd[31:0],      32'h99);
    check("pre_reset_rbusy0", 32'(rbusy[0]), 32'h1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    check("midreset_init_done", 32'(init_done), 32'h0);
    check("midreset_rd0",       rd[31:0],       32'h0);
    check("midreset_rbusy0",    32'(rbusy[0]),  32'h0);
    wait_init("second");
    ra = {5'd4, 5'd4};
    #1;
    check("reinit_x4_rd0",    rd[31:0],      32'h0);
    check("reinit_x4_rd1",    rd[63:32],     32'h0);
    check("reinit_x4_rbusy",  32'(rbusy),    32'h0);
    check("reinit_init_done", 32'(init_done), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
